// File: rtl/oka_mul_seq.sv
// Bit-serial overlap-free Karatsuba carry-less multiplier, GF(2)[x].
// Define OKA_KARATSUBA_EN for three accumulators instead of four.
module oka_mul_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] p
);

    localparam int H  = N / 2;
    localparam int W  = 2 * H - 1;
    localparam int CW = $clog2(H) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [H-1:0]   ae, ao, be, bo;
    logic [W-1:0]   sh_e_q, sh_o_q;
    logic [H-1:0]   be_q, bo_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   acc_p1_q, acc_p4_q;
    logic [W-1:0]   p1_n, p4_n, m;
    logic [2*N-2:0] p_q, p_n;
    logic           se, so, last;

`ifdef OKA_KARATSUBA_EN
    logic [W-1:0]   acc_p3_q, p3_n;
`else
    logic [W-1:0]   acc_x1_q, acc_x2_q, x1_n, x2_n;
`endif

    always_comb begin
        ae = '0;
        ao = '0;
        be = '0;
        bo = '0;
        for (int i = 0; i < H; i++) begin
            ae[i] = a[2*i];
            ao[i] = a[2*i+1];
            be[i] = b[2*i];
            bo[i] = b[2*i+1];
        end
    end

    assign se   = be_q[0];
    assign so   = bo_q[0];
    assign last = (cnt_q == CW'(H - 1));

    assign p1_n = acc_p1_q ^ (se ? sh_e_q : '0);
    assign p4_n = acc_p4_q ^ (so ? sh_o_q : '0);

`ifdef OKA_KARATSUBA_EN
    assign p3_n = acc_p3_q ^ ((se ^ so) ? (sh_e_q ^ sh_o_q) : '0);
    assign m    = p3_n ^ p1_n ^ p4_n;
`else
    assign x1_n = acc_x1_q ^ (so ? sh_e_q : '0);
    assign x2_n = acc_x2_q ^ (se ? sh_o_q : '0);
    assign m    = x1_n ^ x2_n;
`endif

    // Even product bits carry P1 and P4 shifted by one; odd bits are the middle term.
    always_comb begin
        p_n = '0;
        for (int i = 0; i < W; i++) begin
            p_n[2*i]   = p_n[2*i] ^ p1_n[i];
            p_n[2*i+1] = m[i];
        end
        for (int i = 0; i < W; i++) begin
            p_n[2*i+2] = p_n[2*i+2] ^ p4_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            cnt_q    <= '0;
            sh_e_q   <= '0;
            sh_o_q   <= '0;
            be_q     <= '0;
            bo_q     <= '0;
            acc_p1_q <= '0;
            acc_p4_q <= '0;
`ifdef OKA_KARATSUBA_EN
            acc_p3_q <= '0;
`else
            acc_x1_q <= '0;
            acc_x2_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_e_q   <= {{(W-H){1'b0}}, ae};
                        sh_o_q   <= {{(W-H){1'b0}}, ao};
                        be_q     <= be;
                        bo_q     <= bo;
                        cnt_q    <= '0;
                        acc_p1_q <= '0;
                        acc_p4_q <= '0;
`ifdef OKA_KARATSUBA_EN
                        acc_p3_q <= '0;
`else
                        acc_x1_q <= '0;
                        acc_x2_q <= '0;
`endif
                    end
                end
                BUSY: begin
                    acc_p1_q <= p1_n;
                    acc_p4_q <= p4_n;
`ifdef OKA_KARATSUBA_EN
                    acc_p3_q <= p3_n;
`else
                    acc_x1_q <= x1_n;
                    acc_x2_q <= x2_n;
`endif
                    sh_e_q   <= sh_e_q << 1;
                    sh_o_q   <= sh_o_q << 1;
                    be_q     <= be_q >> 1;
                    bo_q     <= bo_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) p_q <= p_n;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule

// File: tb/tb_oka_mul_seq.sv
// Directed-table and random bench for oka_mul_seq, N = 32.
module tb_oka_mul_seq;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*N-2:0] p;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [62:0] exp;
    } vec_t;

    vec_t vecs[10];

    oka_mul_seq #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p)
    );

    always #5 clk = ~clk;

    function automatic logic [62:0] clmul(input logic [31:0] x, input logic [31:0] y);
        logic [62:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (y[i]) r = r ^ ({31'b0, x} << i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic op(input logic [31:0] va, input logic [31:0] vb,
                      input logic [62:0] exp, input bit chk_lat);
        int w;
        int lat;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~va;
        b = $urandom;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_lat) chk("latency", 64'(lat), 64'd16);
        else chk("out_valid_seen", {63'b0, out_valid}, 64'd1);
        chk("p", {1'b0, p}, {1'b0, exp});
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", {63'b0, out_valid}, 64'd0);
        chk("in_ready_after_take", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [62:0] held;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h00000003, 32'h00000003, 63'h5};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 63'h5555555555555555};
        vecs[2] = '{32'h80000000, 32'h80000000, 63'h4000000000000000};
        vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 63'h0};
        vecs[4] = '{32'h00000005, 32'h00000003, 63'hF};
        vecs[5] = '{32'h00000001, 32'hDEADBEEF, 63'hDEADBEEF};
        vecs[6] = '{32'h00000002, 32'h80000000, 63'h100000000};
        vecs[7] = '{32'h0000000F, 32'h0000000F, 63'h55};
        vecs[8] = '{32'h00010001, 32'h00010001, 63'h100000001};
        vecs[9] = '{32'h00000007, 32'h00000003, 63'h9};

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_p", {1'b0, p}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            handoff();
        end

        // Stall in DONE with stray in_valid pulses.
        op(32'h0000ABCD, 32'h00001234, clmul(32'h0000ABCD, 32'h00001234), 1'b1);
        held = p;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0];
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            chk("hold_p", {1'b0, p}, {1'b0, held});
            chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        handoff();

        // Reset mid-computation.
        @(negedge clk);
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_p", {1'b0, p}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op(32'h5, 32'h3, 63'hF, 1'b1);
        handoff();

        // Back-to-back random traffic with the consumer always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            op(ra, rb, clmul(ra, rb), 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
